// File: rtl/mobo_bus_bridge.sv
// mobo_bus_bridge
//   Bridges a single CPU request/response port onto NDEV device channels that
//   use a four-phase strobe/acknowledge handshake. The top SELW address bits
//   select the device; the remaining low bits are passed on as the offset.
//
//   Optional build macro: MOBO_BUS_BRIDGE_TIMEOUT_EN
//     defined   -> handshake timeout after TMO_CYCLES cycles, reported as error
//     undefined -> the bridge waits indefinitely for the device
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     cpu_req/we/addr/wdata   CPU request (sampled in IDLE only)
//     cpu_busy/done/err/rdata CPU response, all registered
//     dev_rd/dev_wr       per-device read/write strobes (at most one high)
//     dev_ack             per-device acknowledge
//     dev_addr/dev_wdata  shared device address (select bits zeroed) and data
//     dev_rdata           per-device read data, device k at [k*DW +: DW]
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for cpu_req
//   WAIT_IDLE | waiting for the selected device's ack to be low
//   REQ       | strobe high, waiting for ack
//   RELEASE   | strobe low, waiting for ack to return low
//   DONE      | one-cycle completion pulse, then back to IDLE
module mobo_bus_bridge #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int NDEV       = 2,
   parameter int TMO_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [DW-1:0]        cpu_wdata,
   output logic                 cpu_busy,
   output logic                 cpu_done,
   output logic                 cpu_err,
   output logic [DW-1:0]        cpu_rdata,
   output logic [NDEV-1:0]      dev_rd,
   output logic [NDEV-1:0]      dev_wr,
   input  logic [NDEV-1:0]      dev_ack,
   output logic [AW-1:0]        dev_addr,
   output logic [DW-1:0]        dev_wdata,
   input  logic [NDEV*DW-1:0]   dev_rdata
);

   localparam int SELW = (NDEV > 1) ? $clog2(NDEV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_REQ,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_err, w_err_nxt;
   logic [DW-1:0]     r_rdata, w_rdata_nxt;
   logic [NDEV-1:0]   r_dev_rd, w_dev_rd_nxt;
   logic [NDEV-1:0]   r_dev_wr, w_dev_wr_nxt;
   logic [AW-1:0]     r_dev_addr, w_dev_addr_nxt;
   logic [DW-1:0]     r_dev_wdata, w_dev_wdata_nxt;
   logic              r_we, w_we_nxt;
   logic [SELW-1:0]   r_idx, w_idx_nxt;

   logic [SELW-1:0]   w_req_idx;
   logic              w_req_idx_ok;
   logic              w_sel_ack;
   logic [NDEV-1:0]   w_sel_bit;

`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0]     r_tmo, w_tmo_nxt;
`else
   // TMO_CYCLES has no function in this build
   if (TMO_CYCLES < 0) begin : g_tmo_unused
   end
`endif

   assign w_req_idx    = cpu_addr[AW-1 -: SELW];
   assign w_req_idx_ok = (int'(w_req_idx) < NDEV);
   assign w_sel_ack    = dev_ack[r_idx];

   always_comb begin
      w_sel_bit        = '0;
      w_sel_bit[r_idx] = 1'b1;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_err_nxt       = r_err;
      w_rdata_nxt     = r_rdata;
      w_dev_rd_nxt    = r_dev_rd;
      w_dev_wr_nxt    = r_dev_wr;
      w_dev_addr_nxt  = r_dev_addr;
      w_dev_wdata_nxt = r_dev_wdata;
      w_we_nxt        = r_we;
      w_idx_nxt       = r_idx;
`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
      w_tmo_nxt       = r_tmo;
`endif

      case (r_state)
         S_IDLE: begin
            if (cpu_req) begin
               w_busy_nxt      = 1'b1;
               w_we_nxt        = cpu_we;
               w_idx_nxt       = w_req_idx;
               w_dev_addr_nxt  = {{SELW{1'b0}}, cpu_addr[AW-SELW-1:0]};
               w_dev_wdata_nxt = cpu_wdata;
               w_err_nxt       = 1'b0;
               if (w_req_idx_ok) begin
                  w_state_nxt = S_WAIT_IDLE;
`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
                  w_tmo_nxt   = '0;
`endif
               end else begin
                  // decode error: straight to completion, no strobe
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = 1'b1;
                  if (!cpu_we) w_rdata_nxt = '0;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (!w_sel_ack) begin
               if (r_we) w_dev_wr_nxt = w_sel_bit;
               else      w_dev_rd_nxt = w_sel_bit;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (w_sel_ack) begin
               w_dev_rd_nxt = '0;
               w_dev_wr_nxt = '0;
               if (!r_we) w_rdata_nxt = dev_rdata[int'(r_idx)*DW +: DW];
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!w_sel_ack) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
               w_err_nxt   = 1'b0;
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
      // timeout overrides whatever the handshake states decided this cycle
      if ((r_state == S_WAIT_IDLE) || (r_state == S_REQ) || (r_state == S_RELEASE)) begin
         if (r_tmo == TW'(TMO_CYCLES)) begin
            w_dev_rd_nxt = '0;
            w_dev_wr_nxt = '0;
            w_rdata_nxt  = r_we ? r_rdata : '0;
            w_done_nxt   = 1'b1;
            w_err_nxt    = 1'b1;
            w_state_nxt  = S_DONE;
         end else begin
            w_tmo_nxt = TW'(r_tmo + 1'b1);
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_dev_rd    <= '0;
         r_dev_wr    <= '0;
         r_dev_addr  <= '0;
         r_dev_wdata <= '0;
         r_we        <= 1'b0;
         r_idx       <= '0;
`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
         r_tmo       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_err       <= w_err_nxt;
         r_rdata     <= w_rdata_nxt;
         r_dev_rd    <= w_dev_rd_nxt;
         r_dev_wr    <= w_dev_wr_nxt;
         r_dev_addr  <= w_dev_addr_nxt;
         r_dev_wdata <= w_dev_wdata_nxt;
         r_we        <= w_we_nxt;
         r_idx       <= w_idx_nxt;
`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
         r_tmo       <= w_tmo_nxt;
`endif
      end
   end

   assign cpu_busy  = r_busy;
   assign cpu_done  = r_done;
   assign cpu_err   = r_err;
   assign cpu_rdata = r_rdata;
   assign dev_rd    = r_dev_rd;
   assign dev_wr    = r_dev_wr;
   assign dev_addr  = r_dev_addr;
   assign dev_wdata = r_dev_wdata;

endmodule

// File: tb/tb_mobo_bus_bridge.sv
// Bench for mobo_bus_bridge: a 2-device and a 3-device instance, each device
// modelled as a registered acknowledger (ack follows strobe one cycle later).
module tb_mobo_bus_bridge;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req2, req3, we;
   logic [31:0] addr, wdata;

   logic        busy2, done2, err2;
   logic [31:0] rdata2, daddr2, dwd2;
   logic [1:0]  rd2, wr2, ack2;
   logic [63:0] din2;

   logic        busy3, done3, err3;
   logic [31:0] rdata3, daddr3, dwd3;
   logic [2:0]  rd3, wr3, ack3;
   logic [95:0] din3;

   logic [2:0]  en, hold;

   assign din2 = {32'hCAFE_0001, 32'hBEEF_0000};
   assign din3 = {32'h3222_2222, 32'h3111_1111, 32'h3000_0000};

   mobo_bus_bridge #(.DW(32), .AW(32), .NDEV(2), .TMO_CYCLES(8)) dut2 (
      .clk(clk), .rst(rst), .cpu_req(req2), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_busy(busy2), .cpu_done(done2), .cpu_err(err2),
      .cpu_rdata(rdata2), .dev_rd(rd2), .dev_wr(wr2), .dev_ack(ack2),
      .dev_addr(daddr2), .dev_wdata(dwd2), .dev_rdata(din2));

   mobo_bus_bridge #(.DW(32), .AW(32), .NDEV(3), .TMO_CYCLES(8)) dut3 (
      .clk(clk), .rst(rst), .cpu_req(req3), .cpu_we(we), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_busy(busy3), .cpu_done(done3), .cpu_err(err3),
      .cpu_rdata(rdata3), .dev_rd(rd3), .dev_wr(wr3), .dev_ack(ack3),
      .dev_addr(daddr3), .dev_wdata(dwd3), .dev_rdata(din3));

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack2 <= '0;
         ack3 <= '0;
      end else begin
         ack2 <= ((rd2 | wr2) & en[1:0]) | hold[1:0];
         ack3 <= ((rd3 | wr3) & en) | hold;
      end
   end

   // observation mux: sel=0 -> dut2, sel=1 -> dut3
   logic        sel;
   logic        s_busy, s_done, s_err;
   logic [31:0] s_rdata, s_daddr, s_dwd;
   logic [2:0]  s_rd, s_wr;
   assign s_busy  = sel ? busy3  : busy2;
   assign s_done  = sel ? done3  : done2;
   assign s_err   = sel ? err3   : err2;
   assign s_rdata = sel ? rdata3 : rdata2;
   assign s_daddr = sel ? daddr3 : daddr2;
   assign s_dwd   = sel ? dwd3   : dwd2;
   assign s_rd    = sel ? rd3    : {1'b0, rd2};
   assign s_wr    = sel ? wr3    : {1'b0, wr2};

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          dut;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_dev;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   vec_t tv [9];

   task automatic run(input vec_t v, input string tag);
      int lat, shi, bad, abad;
      logic [2:0] one;
      lat = -1; shi = 0; bad = 0; abad = 0; one = 3'b001;
      sel = v.dut;
      @(negedge clk);
      we = v.we; addr = v.addr; wdata = v.wdata;
      if (v.dut) req3 = 1'b1; else req2 = 1'b1;
      for (int n = 0; n < 30 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (n == 0) begin
            req2 = 1'b0; req3 = 1'b0;
            chk({tag, " busy_at_accept"}, 64'(s_busy), 64'd1);
         end
         if ((s_rd | s_wr) != 3'b000) begin
            if (v.exp_dev < 0 || (s_rd | s_wr) != (one << v.exp_dev) ||
                (v.we ? (s_rd != 3'b000) : (s_wr != 3'b000)))
               bad++;
            else begin
               shi++;
               if (s_daddr !== v.exp_addr || (v.we && s_dwd !== v.wdata)) abad++;
            end
         end
         if (s_done) lat = n;
      end
      chk({tag, " done_latency"}, 64'(lat), 64'(v.exp_lat));
      chk({tag, " err"}, 64'(s_err), 64'(v.exp_err));
      chk({tag, " rdata"}, 64'(s_rdata), 64'(v.exp_rdata));
      chk({tag, " strobe_cycles"}, 64'(shi), (v.exp_dev < 0) ? 64'd0 : 64'd2);
      chk({tag, " wrong_strobe"}, 64'(bad), 64'd0);
      chk({tag, " dev_addr_wdata"}, 64'(abad), 64'd0);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 64'(s_done), 64'd0);
      chk({tag, " busy_cleared"}, 64'(s_busy), 64'd0);
   endtask

   initial begin
      int lat, viol, shi;

      tv[0] = '{0, 0, 32'h8000_0010, 32'h0,     1,  32'h0000_0010, 32'hCAFE_0001, 0, 5};
      tv[1] = '{0, 1, 32'h0000_0005, 32'h205,   0,  32'h0000_0005, 32'hCAFE_0001, 0, 5};
      tv[2] = '{0, 0, 32'h0000_0040, 32'h0,     0,  32'h0000_0040, 32'hBEEF_0000, 0, 5};
      tv[3] = '{0, 1, 32'h8000_0100, 32'h1234,  1,  32'h0000_0100, 32'hBEEF_0000, 0, 5};
      tv[4] = '{0, 0, 32'hFFFF_FFFC, 32'h0,     1,  32'h7FFF_FFFC, 32'hCAFE_0001, 0, 5};
      tv[5] = '{1, 0, 32'h8000_0020, 32'h0,     2,  32'h0000_0020, 32'h3222_2222, 0, 5};
      tv[6] = '{1, 0, 32'hC000_0000, 32'h0,     -1, 32'h0,         32'h0,         1, 0};
      tv[7] = '{1, 0, 32'h4000_0004, 32'h0,     1,  32'h0000_0004, 32'h3111_1111, 0, 5};
      tv[8] = '{1, 1, 32'hC000_0008, 32'h77,    -1, 32'h0,         32'h3111_1111, 1, 0};

      rst = 1'b1; req2 = 1'b0; req3 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      en = 3'b111; hold = 3'b000; sel = 1'b0;
      #2;
      chk("reset dut2 outputs", {busy2, done2, err2, rd2, wr2, rdata2, daddr2[15:0], dwd2[7:0]}, 64'd0);
      chk("reset dut3 outputs", {busy3, done3, err3, rd3, wr3, rdata3, daddr3[15:0], dwd3[7:0]}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 9; i++) run(tv[i], $sformatf("vec%0d", i));

      // dev_ack[0] stuck high before the request; a second cpu_req while busy is ignored
      sel = 1'b0; hold = 3'b001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      we = 1'b1; addr = 32'h0000_0008; wdata = 32'h55; req2 = 1'b1;
      @(posedge clk); #1;
      we = 1'b0; addr = 32'h8000_0000; wdata = 32'h99;
      viol = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (s_rd != 3'b000 || s_wr != 3'b000 || !s_busy || s_done) viol++;
      end
      chk("ack_held waits in WAIT_IDLE", 64'(viol), 64'd0);
      req2 = 1'b0; hold = 3'b000;
      lat = -1; viol = 0; shi = 0;
      for (int n = 0; n < 20 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (s_rd != 3'b000 || (s_wr != 3'b000 && s_wr != 3'b001)) viol++;
         if (s_wr == 3'b001) begin
            shi++;
            if (s_daddr !== 32'h8 || s_dwd !== 32'h55) viol++;
         end
         if (s_done) lat = n;
      end
      chk("ack_held completes", 64'(lat >= 0), 64'd1);
      chk("ack_held latched request kept", 64'(viol), 64'd0);
      chk("ack_held strobe seen", 64'(shi), 64'd2);
      chk("ack_held err", 64'(s_err), 64'd0);
      chk("ack_held rdata unchanged", 64'(s_rdata), 64'hCAFE_0001);
      @(posedge clk); #1;

      // device 1 never acknowledges
      en = 3'b101;
      @(negedge clk);
      we = 1'b0; addr = 32'h8000_0000; req2 = 1'b1;
      @(posedge clk); #1;
      req2 = 1'b0;
`ifdef MOBO_BUS_BRIDGE_TIMEOUT_EN
      lat = -1;
      for (int n = 1; n < 40 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (s_done) lat = n;
      end
      chk("timeout latency", 64'(lat), 64'd9);
      chk("timeout err", 64'(s_err), 64'd1);
      chk("timeout strobes low", 64'({s_rd, s_wr}), 64'd0);
      chk("timeout rdata cleared", 64'(s_rdata), 64'd0);
      @(posedge clk); #1;
      chk("timeout busy cleared", 64'(s_busy), 64'd0);
`else
      viol = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (!s_busy || s_done) viol++;
      end
      chk("no_ack stays busy", 64'(viol), 64'd0);
      chk("no_ack strobe held", 64'(s_rd), 64'b010);
`endif
      en = 3'b111;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      run(tv[2], "pre_reset");

      // reset while in REQ with the strobe high
      sel = 1'b0;
      @(negedge clk);
      we = 1'b0; addr = 32'h8000_0010; req2 = 1'b1;
      @(posedge clk); #1;
      req2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_req strobe high", 64'(rd2), 64'b10);
      rst = 1'b1;
      #1;
      chk("mid_req reset strobe", 64'({rd2, wr2}), 64'd0);
      chk("mid_req reset busy", 64'(busy2), 64'd0);
      chk("mid_req reset rdata", 64'(rdata2), 64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_req no resume", 64'({busy2, rd2, wr2}), 64'd0);
      run(tv[0], "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
